decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered RISC-V instruction decode stage with valid/ready handshakes on both sides and a one-entry skid buffer.
- Sits between fetch and register-read/execute. Accepts instruction plus PC; emits a decoded bundle one cycle later.
- Generalised over XLEN (32/64), with sign-extended immediates, per-field legality checking, x0-write suppression and pipeline flush.

Parameters:
- XLEN, 32, data/immediate width; legal values 32 or 64.
- PC_WIDTH, XLEN, width of the PC carried alongside the instruction.
- SKID_ENABLE, 1, 1 = skid buffer present (in_ready registered); 0 = in_ready = out_ready || !out_valid (combinational).

Ports:
- clk  in  1  clock (all state on rising edge)
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage can accept this cycle
- in_instruction  in  32  raw instruction word
- in_pc  in  PC_WIDTH  PC of the instruction
- flush  in  1  discard all held and incoming instructions
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts bundle
- out_pc  out  PC_WIDTH  PC of the decoded instruction
- out_op  out  4  op class (op_t): OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, OP_32, OP_IMM_32, NONE
- out_immediate  out  XLEN  sign-extended immediate, 0 when none
- out_rs1 / out_rs2 / out_rd  out  5 each  register indices
- out_rs1_valid / out_rs2_valid / out_rd_valid  out  1 each  field meaningful
- out_funct3  out  3  instruction[14:12]
- out_funct7  out  7  instruction[31:25]
- out_illegal  out  1  instruction failed legality check

Behaviour:
- Reset: while rst is high and on the cycle after it, out_valid=0, skid empty and all bundle outputs 0. in_ready=0 while rst is high and 1 on the first cycle after rst deasserts.
- Transfers: input transfer = in_valid && in_ready; output transfer = out_valid && out_ready. in_instruction and in_pc must be held stable while in_valid && !in_ready.
- Latency: 1 cycle. An instruction accepted at edge N appears on out_* after edge N when the output register is empty or draining.
- Output register load: loads when (!out_valid || out_ready). Its source is the skid entry if the skid is full, otherwise the incoming decode.
- Skid capture: when out_valid && !out_ready && input transfer, the decoded bundle is captured into the skid. in_ready drops to 0 the next cycle.
- Skid release: when the output transfers and the skid is full, the skid entry moves to the output register and in_ready returns to 1 the next cycle.
- Ordering: program order is always preserved, and no bundle is ever duplicated or dropped except by flush.
- Simultaneous accept and drain with the skid empty: the new bundle goes straight to the output register.
- Flush (priority over everything except rst): the next cycle has out_valid=0 and an empty skid, and in_ready=1 in that cycle. Any input transfer in the flush cycle is discarded.
- Decode is combinational, performed before the register stage by the sub-module.
- Immediates: I, S, B, U and J formats follow the RISC-V base spec and are sign-extended from instruction[31] to XLEN. U-type is {instr[31:12],12'b0} sign-extended. R-type gives 0.
- rd_valid: = writes_rd && (rd != 0), so x0 writes are suppressed. rs1_valid and rs2_valid follow the format.
- Illegal cases:
  - instr[1:0] != 2'b11, or unknown opcode;
  - R-type funct7 not 0000000/0100000, or 0100000 with funct3 not 000/101;
  - shift-immediate upper-bits violation (funct7 for XLEN=32; instr[31:26] for XLEN=64);
  - LOAD funct3 111, or 011/110 when XLEN=32;
  - STORE funct3 >= 100, or 011 when XLEN=32;
  - BRANCH funct3 010/011;
  - JALR funct3 != 000;
  - OP_32/OP_IMM_32 when XLEN=32.
- Illegal handling: an illegal instruction still flows through as a bundle with out_illegal=1, out_op=NONE, all *_valid=0 and immediate 0.

Decomposition:
- Package decode_pkg: op_t enum, opcode constants, funct3 constants, and decoded_t struct (op, imm, rs1, rs2, rd, valids, funct3, funct7, illegal, pc). The skid buffer and output register both hold decoded_t.
- Sub-module decode_logic: purely combinational, instruction -> decoded_t, parametrised by XLEN. decode_stage holds only handshake and register state.

Test Plan:
- XLEN=32, addi x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle out_op=OP_IMM, imm=0xFFFFFFFF, rd=1, rd_valid=1, rs1=0, rs1_valid=1, illegal=0.
- beq x0,x0,-4 (0xFE000EE3) -> imm=0xFFFFFFFC, rs1_valid=rs2_valid=1, rd_valid=0. addi x0,x0,0 (0x00000013) -> rd_valid=0.
- Backpressure: out_ready=0, offer A, B, C back-to-back -> A on output, B in skid, in_ready=0, C held. Then out_ready=1 -> A, B, C emitted in order on consecutive cycles with none lost.
- Flush with output and skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1. The instruction offered during flush never appears.
- 0x00000000 and 0x0000707B -> out_illegal=1, out_op=NONE, all valids 0. Also in the XLEN=32 build, ld (0x0000B003) -> illegal.
- XLEN=64, lui x5,0x80000 (0x800002B7) -> imm=0xFFFFFFFF80000000, rd=5. rst asserted mid-stall -> out_valid=0 and skid empty after the reset edge.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types for the RISC-V decode stage: op classes, opcode/funct constants
// and the decoded bundle carried by the skid buffer and the output register.
package decode_pkg;

   typedef enum logic [3:0] {
      OP        = 4'd0,
      OP_IMM    = 4'd1,
      LOAD      = 4'd2,
      STORE     = 4'd3,
      BRANCH    = 4'd4,
      JAL       = 4'd5,
      JALR      = 4'd6,
      LUI       = 4'd7,
      AUIPC     = 4'd8,
      SYSTEM    = 4'd9,
      OP_32     = 4'd10,
      OP_IMM_32 = 4'd11,
      NONE      = 4'd12
   } op_t;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_BR_RSV0 = 3'b010;
   localparam logic [2:0] F3_BR_RSV1 = 3'b011;
   localparam logic [2:0] F3_LD_SD   = 3'b011;
   localparam logic [2:0] F3_SR      = 3'b101;
   localparam logic [2:0] F3_LWU     = 3'b110;
   localparam logic [2:0] F3_LD_RSV  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // imm and pc are stored at the widest supported size; the stage trims them.
   typedef struct packed {
      op_t         op;
      logic [63:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rs1Valid;
      logic        rs2Valid;
      logic        rdValid;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic        illegal;
      logic [63:0] pc;
   } decoded_t;

   function automatic logic rTypeLegal(input logic [2:0] funct3, input logic [6:0] funct7);
      return (funct7 == F7_BASE) ||
             ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SR)));
   endfunction

   function automatic logic shiftLegal32(input logic [2:0] funct3, input logic [6:0] funct7);
      return (funct3 == F3_SLL) ? (funct7 == F7_BASE)
                                : ((funct7 == F7_BASE) || (funct7 == F7_ALT));
   endfunction

   function automatic logic shiftLegal64(input logic [2:0] funct3, input logic [5:0] upper6);
      return (funct3 == F3_SLL) ? (upper6 == 6'b000000)
                                : ((upper6 == 6'b000000) || (upper6 == 6'b010000));
   endfunction

endpackage

// File: rtl/decode_logic.sv
// Purely combinational RISC-V instruction decoder: raw word -> decoded_t.
// The pc field is left zero; the stage fills it in.
module decode_logic
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0] i_instruction,
   output decoded_t    o_decoded
);

   localparam bit IS64 = (XLEN == 64);

   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic [6:0]  w_funct7;
   logic [4:0]  w_rd;
   logic [63:0] w_immI;
   logic [63:0] w_immS;
   logic [63:0] w_immB;
   logic [63:0] w_immU;
   logic [63:0] w_immJ;
   logic        w_isShift;

   op_t         w_op;
   logic [63:0] w_imm;
   logic        w_rs1Valid;
   logic        w_rs2Valid;
   logic        w_writesRd;
   logic        w_illegal;

   assign w_opcode  = i_instruction[6:0];
   assign w_funct3  = i_instruction[14:12];
   assign w_funct7  = i_instruction[31:25];
   assign w_rd      = i_instruction[11:7];
   assign w_isShift = (w_funct3 == F3_SLL) || (w_funct3 == F3_SR);

   assign w_immI = {{52{i_instruction[31]}}, i_instruction[31:20]};
   assign w_immS = {{52{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
   assign w_immB = {{52{i_instruction[31]}}, i_instruction[7], i_instruction[30:25],
                    i_instruction[11:8], 1'b0};
   assign w_immU = {{32{i_instruction[31]}}, i_instruction[31:12], 12'b0};
   assign w_immJ = {{44{i_instruction[31]}}, i_instruction[19:12], i_instruction[20],
                    i_instruction[30:21], 1'b0};

   always_comb begin
      w_op       = NONE;
      w_imm      = '0;
      w_rs1Valid = 1'b0;
      w_rs2Valid = 1'b0;
      w_writesRd = 1'b0;
      w_illegal  = 1'b0;
      case (w_opcode)
         OPC_OP: begin
            w_op = OP; w_rs1Valid = 1'b1; w_rs2Valid = 1'b1; w_writesRd = 1'b1;
            w_illegal = !rTypeLegal(w_funct3, w_funct7);
         end
         OPC_OP_32: begin
            w_op = OP_32; w_rs1Valid = 1'b1; w_rs2Valid = 1'b1; w_writesRd = 1'b1;
            w_illegal = !IS64 || !rTypeLegal(w_funct3, w_funct7);
         end
         OPC_OP_IMM: begin
            w_op = OP_IMM; w_imm = w_immI; w_rs1Valid = 1'b1; w_writesRd = 1'b1;
            // RV64 shifts use a 6-bit shamt, so only instr[31:26] is reserved.
            if (w_isShift)
               w_illegal = IS64 ? !shiftLegal64(w_funct3, i_instruction[31:26])
                                : !shiftLegal32(w_funct3, w_funct7);
         end
         OPC_OP_IMM_32: begin
            w_op = OP_IMM_32; w_imm = w_immI; w_rs1Valid = 1'b1; w_writesRd = 1'b1;
            w_illegal = !IS64 || (w_isShift && !shiftLegal32(w_funct3, w_funct7));
         end
         OPC_LOAD: begin
            w_op = LOAD; w_imm = w_immI; w_rs1Valid = 1'b1; w_writesRd = 1'b1;
            w_illegal = (w_funct3 == F3_LD_RSV) ||
                        (!IS64 && ((w_funct3 == F3_LD_SD) || (w_funct3 == F3_LWU)));
         end
         OPC_STORE: begin
            w_op = STORE; w_imm = w_immS; w_rs1Valid = 1'b1; w_rs2Valid = 1'b1;
            w_illegal = w_funct3[2] || (!IS64 && (w_funct3 == F3_LD_SD));
         end
         OPC_BRANCH: begin
            w_op = BRANCH; w_imm = w_immB; w_rs1Valid = 1'b1; w_rs2Valid = 1'b1;
            w_illegal = (w_funct3 == F3_BR_RSV0) || (w_funct3 == F3_BR_RSV1);
         end
         OPC_JAL: begin
            w_op = JAL; w_imm = w_immJ; w_writesRd = 1'b1;
         end
         OPC_JALR: begin
            w_op = JALR; w_imm = w_immI; w_rs1Valid = 1'b1; w_writesRd = 1'b1;
            w_illegal = (w_funct3 != F3_ADD_SUB);
         end
         OPC_LUI: begin
            w_op = LUI; w_imm = w_immU; w_writesRd = 1'b1;
         end
         OPC_AUIPC: begin
            w_op = AUIPC; w_imm = w_immU; w_writesRd = 1'b1;
         end
         OPC_SYSTEM: begin
            w_op = SYSTEM; w_imm = w_immI; w_rs1Valid = 1'b1; w_writesRd = 1'b1;
         end
         default: w_illegal = 1'b1;
      endcase
      if (i_instruction[1:0] != 2'b11)
         w_illegal = 1'b1;
   end

   // Illegal words still travel as bundles, but carry no usable operands.
   always_comb begin
      o_decoded          = '0;
      o_decoded.op       = w_illegal ? NONE : w_op;
      o_decoded.imm      = w_illegal ? 64'd0 : w_imm;
      o_decoded.rs1      = i_instruction[19:15];
      o_decoded.rs2      = i_instruction[24:20];
      o_decoded.rd       = w_rd;
      o_decoded.rs1Valid = w_rs1Valid && !w_illegal;
      o_decoded.rs2Valid = w_rs2Valid && !w_illegal;
      o_decoded.rdValid  = w_writesRd && (w_rd != 5'd0) && !w_illegal;
      o_decoded.funct3   = w_funct3;
      o_decoded.funct7   = w_funct7;
      o_decoded.illegal  = w_illegal;
   end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready on both sides and a one-entry skid
// buffer so that in_ready need not depend combinationally on out_ready.
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int PC_WIDTH    = XLEN,
   parameter bit SKID_ENABLE = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_instruction,
   input  logic [PC_WIDTH-1:0] in_pc,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [PC_WIDTH-1:0] out_pc,
   output logic [3:0]          out_op,
   output logic [XLEN-1:0]     out_immediate,
   output logic [4:0]          out_rs1,
   output logic [4:0]          out_rs2,
   output logic [4:0]          out_rd,
   output logic                out_rs1_valid,
   output logic                out_rs2_valid,
   output logic                out_rd_valid,
   output logic [2:0]          out_funct3,
   output logic [6:0]          out_funct7,
   output logic                out_illegal
);

   decoded_t r_outBundle;
   decoded_t r_skidBundle;
   logic     r_outValid;
   logic     r_skidValid;

   decoded_t w_rawDec;
   decoded_t w_dec;
   logic     w_inXfer;
   logic     w_outLoad;
   logic     w_unused;

   decode_logic #(.XLEN(XLEN)) u_decodeLogic (
      .i_instruction (in_instruction),
      .o_decoded     (w_rawDec)
   );

   always_comb begin
      w_dec    = w_rawDec;
      w_dec.pc = 64'(in_pc);
   end

   // With the skid present, in_ready is simply "skid empty", a registered term.
   assign in_ready  = !rst && (SKID_ENABLE ? !r_skidValid : (out_ready || !r_outValid));
   assign w_inXfer  = in_valid && in_ready;
   assign w_outLoad = !r_outValid || out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_outValid   <= 1'b0;
         r_skidValid  <= 1'b0;
         r_outBundle  <= '0;
         r_skidBundle <= '0;
      end else if (flush) begin
         r_outValid  <= 1'b0;
         r_skidValid <= 1'b0;
      end else if (w_outLoad) begin
         if (r_skidValid) begin
            r_outBundle <= r_skidBundle;
            r_outValid  <= 1'b1;
            r_skidValid <= 1'b0;
         end else begin
            if (w_inXfer)
               r_outBundle <= w_dec;
            r_outValid <= w_inXfer;
         end
      end else if (w_inXfer) begin
         r_skidBundle <= w_dec;
         r_skidValid  <= 1'b1;
      end
   end

   assign out_valid     = r_outValid && !rst;
   assign out_pc        = r_outBundle.pc[PC_WIDTH-1:0];
   assign out_op        = r_outBundle.op;
   assign out_immediate = r_outBundle.imm[XLEN-1:0];
   assign out_rs1       = r_outBundle.rs1;
   assign out_rs2       = r_outBundle.rs2;
   assign out_rd        = r_outBundle.rd;
   assign out_rs1_valid = r_outBundle.rs1Valid;
   assign out_rs2_valid = r_outBundle.rs2Valid;
   assign out_rd_valid  = r_outBundle.rdValid;
   assign out_funct3    = r_outBundle.funct3;
   assign out_funct7    = r_outBundle.funct7;
   assign out_illegal   = r_outBundle.illegal;

   assign w_unused = ^r_outBundle;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: an XLEN=32 and an XLEN=64 instance, each
// with its own expectation queue popped by a monitor on every output transfer.
module tb_decode_stage;
   import decode_pkg::*;

   typedef struct packed {
      logic [3:0]  op;
      logic [63:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  vals;
      logic        ill;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [63:0] pc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        inValid32 = 1'b0, inReady32, flush32 = 1'b0, outValid32, outReady32 = 1'b1;
   logic [31:0] instr32 = '0, pc32 = '0, outPc32, outImm32;
   logic [3:0]  outOp32;
   logic [4:0]  outRs1_32, outRs2_32, outRd32;
   logic        outRs1V32, outRs2V32, outRdV32, outIll32;
   logic [2:0]  outF3_32;
   logic [6:0]  outF7_32;

   logic        inValid64 = 1'b0, inReady64, flush64 = 1'b0, outValid64, outReady64 = 1'b1;
   logic [31:0] instr64 = '0;
   logic [63:0] pc64 = '0, outPc64, outImm64;
   logic [3:0]  outOp64;
   logic [4:0]  outRs1_64, outRs2_64, outRd64;
   logic        outRs1V64, outRs2V64, outRdV64, outIll64;
   logic [2:0]  outF3_64;
   logic [6:0]  outF7_64;

   int   total = 0;
   int   bad = 0;
   exp_t q32[$];
   exp_t q64[$];

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .PC_WIDTH(32), .SKID_ENABLE(1'b1)) dut32 (
      .clk(clk), .rst(rst), .in_valid(inValid32), .in_ready(inReady32),
      .in_instruction(instr32), .in_pc(pc32), .flush(flush32),
      .out_valid(outValid32), .out_ready(outReady32), .out_pc(outPc32), .out_op(outOp32),
      .out_immediate(outImm32), .out_rs1(outRs1_32), .out_rs2(outRs2_32), .out_rd(outRd32),
      .out_rs1_valid(outRs1V32), .out_rs2_valid(outRs2V32), .out_rd_valid(outRdV32),
      .out_funct3(outF3_32), .out_funct7(outF7_32), .out_illegal(outIll32)
   );

   decode_stage #(.XLEN(64), .PC_WIDTH(64), .SKID_ENABLE(1'b1)) dut64 (
      .clk(clk), .rst(rst), .in_valid(inValid64), .in_ready(inReady64),
      .in_instruction(instr64), .in_pc(pc64), .flush(flush64),
      .out_valid(outValid64), .out_ready(outReady64), .out_pc(outPc64), .out_op(outOp64),
      .out_immediate(outImm64), .out_rs1(outRs1_64), .out_rs2(outRs2_64), .out_rd(outRd64),
      .out_rs1_valid(outRs1V64), .out_rs2_valid(outRs2V64), .out_rd_valid(outRdV64),
      .out_funct3(outF3_64), .out_funct7(outF7_64), .out_illegal(outIll64)
   );

   // vals = {rs1_valid, rs2_valid, rd_valid}; register/funct fields are raw bit slices.
   function automatic exp_t mkExp(input logic [31:0] instr, input logic [3:0] op,
                                  input logic [63:0] imm, input logic [2:0] vals,
                                  input logic ill, input logic [63:0] pc);
      mkExp = {op, imm, instr[19:15], instr[24:20], instr[11:7], vals, ill,
               instr[14:12], instr[31:25], pc};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic checkBundle(input string name, input exp_t act, input exp_t req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s actual op=%0d imm=%0h rs1=%0d rs2=%0d rd=%0d vals=%b ill=%b f3=%0d f7=%0h pc=%0h required op=%0d imm=%0h rs1=%0d rs2=%0d rd=%0d vals=%b ill=%b f3=%0d f7=%0h pc=%0h",
                  name, act.op, act.imm, act.rs1, act.rs2, act.rd, act.vals, act.ill, act.f3, act.f7, act.pc,
                  req.op, req.imm, req.rs1, req.rs2, req.rd, req.vals, req.ill, req.f3, req.f7, req.pc);
      end
   endtask

   task automatic applyStimulus(input bit sel64, input logic [31:0] instr, input logic [63:0] pc,
                                input bit keep, input exp_t e);
      int n;
      bit ok;
      n = 0;
      ok = 1'b0;
      if (sel64) begin inValid64 = 1'b1; instr64 = instr; pc64 = pc; end
      else begin inValid32 = 1'b1; instr32 = instr; pc32 = pc[31:0]; end
      while (!ok && n < 40) begin
         @(negedge clk);
         ok = sel64 ? inReady64 : inReady32;
         @(posedge clk);
         n++;
      end
      if (!ok) begin
         total++;
         bad++;
         $display("[TB] FAIL acceptTimeout actual=not accepted required=accepted instr=%08h", instr);
      end else if (keep) begin
         if (sel64) q64.push_back(e);
         else q32.push_back(e);
      end
      #1;
      if (sel64) inValid64 = 1'b0;
      else inValid32 = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t act, e;
      if (rst == 1'b0 && outValid32 && outReady32) begin
         act = {outOp32, 64'(outImm32), outRs1_32, outRs2_32, outRd32,
                {outRs1V32, outRs2V32, outRdV32}, outIll32, outF3_32, outF7_32, 64'(outPc32)};
         if (q32.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected32 actual=pc %0h required=no bundle", outPc32);
         end else begin
            e = q32.pop_front();
            checkBundle("bundle32", act, e);
         end
      end
   end

   always @(negedge clk) begin
      exp_t act, e;
      if (rst == 1'b0 && outValid64 && outReady64) begin
         act = {outOp64, outImm64, outRs1_64, outRs2_64, outRd64,
                {outRs1V64, outRs2V64, outRdV64}, outIll64, outF3_64, outF7_64, outPc64};
         if (q64.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected64 actual=pc %0h required=no bundle", outPc64);
         end else begin
            e = q64.pop_front();
            checkBundle("bundle64", act, e);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      exp_t none;
      none = '0;

      @(negedge clk);
      checkOutput("rstOutValid", 64'(outValid32), 64'd0);
      checkOutput("rstInReady", 64'(inReady32), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("postRstInReady", 64'(inReady32), 64'd1);
      checkOutput("postRstOutValid", 64'(outValid32), 64'd0);
      checkOutput("postRstImm", 64'(outImm32), 64'd0);
      checkOutput("postRstOp", 64'(outOp32), 64'd0);
      @(posedge clk);
      #1;

      applyStimulus(0, 32'hFFF00093, 64'h100, 1, mkExp(32'hFFF00093, OP_IMM, 64'hFFFFFFFF, 3'b101, 1'b0, 64'h100));
      applyStimulus(0, 32'hFE000EE3, 64'h104, 1, mkExp(32'hFE000EE3, BRANCH, 64'hFFFFFFFC, 3'b110, 1'b0, 64'h104));
      applyStimulus(0, 32'h00000013, 64'h108, 1, mkExp(32'h00000013, OP_IMM, 64'h0, 3'b100, 1'b0, 64'h108));
      applyStimulus(0, 32'h002081B3, 64'h10C, 1, mkExp(32'h002081B3, OP, 64'h0, 3'b111, 1'b0, 64'h10C));
      applyStimulus(0, 32'h402091B3, 64'h110, 1, mkExp(32'h402091B3, NONE, 64'h0, 3'b000, 1'b1, 64'h110));
      applyStimulus(0, 32'h0020A423, 64'h114, 1, mkExp(32'h0020A423, STORE, 64'h8, 3'b110, 1'b0, 64'h114));
      applyStimulus(0, 32'h00000000, 64'h118, 1, mkExp(32'h00000000, NONE, 64'h0, 3'b000, 1'b1, 64'h118));
      applyStimulus(0, 32'h0000707B, 64'h11C, 1, mkExp(32'h0000707B, NONE, 64'h0, 3'b000, 1'b1, 64'h11C));
      applyStimulus(0, 32'h0000B003, 64'h120, 1, mkExp(32'h0000B003, NONE, 64'h0, 3'b000, 1'b1, 64'h120));
      applyStimulus(0, 32'h02009093, 64'h124, 1, mkExp(32'h02009093, NONE, 64'h0, 3'b000, 1'b1, 64'h124));
      applyStimulus(0, 32'h800002B7, 64'h128, 1, mkExp(32'h800002B7, LUI, 64'h80000000, 3'b001, 1'b0, 64'h128));
      applyStimulus(0, 32'h008000EF, 64'h12C, 1, mkExp(32'h008000EF, JAL, 64'h8, 3'b001, 1'b0, 64'h12C));

      applyStimulus(1, 32'h800002B7, 64'h8000_0000_0000_0200, 1,
                    mkExp(32'h800002B7, LUI, 64'hFFFFFFFF80000000, 3'b001, 1'b0, 64'h8000_0000_0000_0200));
      applyStimulus(1, 32'h0000B003, 64'h204, 1, mkExp(32'h0000B003, LOAD, 64'h0, 3'b100, 1'b0, 64'h204));
      applyStimulus(1, 32'h02009093, 64'h208, 1, mkExp(32'h02009093, OP_IMM, 64'h20, 3'b101, 1'b0, 64'h208));

      // Backpressure: A on the output, B in the skid, C held until drain.
      repeat (3) @(posedge clk);
      #1 outReady32 = 1'b0;
      applyStimulus(0, 32'h002081B3, 64'h300, 1, mkExp(32'h002081B3, OP, 64'h0, 3'b111, 1'b0, 64'h300));
      applyStimulus(0, 32'h40208233, 64'h304, 1, mkExp(32'h40208233, OP, 64'h0, 3'b111, 1'b0, 64'h304));
      fork
         applyStimulus(0, 32'hFFF00093, 64'h308, 1, mkExp(32'hFFF00093, OP_IMM, 64'hFFFFFFFF, 3'b101, 1'b0, 64'h308));
         begin
            @(negedge clk);
            checkOutput("skidInReady", 64'(inReady32), 64'd0);
            checkOutput("stallOutValid", 64'(outValid32), 64'd1);
            checkOutput("stallOutPc", 64'(outPc32), 64'h300);
            repeat (2) @(posedge clk);
            #1 outReady32 = 1'b1;
         end
      join

      // Flush with output and skid full while another instruction is offered.
      repeat (3) @(posedge clk);
      #1 outReady32 = 1'b0;
      applyStimulus(0, 32'h00000013, 64'h400, 0, none);
      applyStimulus(0, 32'h002081B3, 64'h404, 0, none);
      inValid32 = 1'b1;
      instr32 = 32'hFFF00093;
      pc32 = 32'h408;
      flush32 = 1'b1;
      @(posedge clk);
      #1 flush32 = 1'b0;
      inValid32 = 1'b0;
      @(negedge clk);
      checkOutput("flushOutValid", 64'(outValid32), 64'd0);
      checkOutput("flushInReady", 64'(inReady32), 64'd1);
      @(posedge clk);
      #1 outReady32 = 1'b1;
      repeat (3) @(posedge clk);

      // Reset arriving while the stage is stalled with the skid full.
      #1 outReady32 = 1'b0;
      applyStimulus(0, 32'h00000013, 64'h500, 0, none);
      applyStimulus(0, 32'h002081B3, 64'h504, 0, none);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("midRstOutValid", 64'(outValid32), 64'd0);
      checkOutput("midRstInReady", 64'(inReady32), 64'd1);
      checkOutput("midRstPc", 64'(outPc32), 64'd0);
      @(posedge clk);
      #1 outReady32 = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      checkOutput("drain32", 64'(q32.size()), 64'd0);
      checkOutput("drain64", 64'(q64.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
